mult_seq16: RTL and testbench

Sequential 16x16 unsigned shift-add multiplier with a start/done handshake. It feeds the MAC accumulator register: it produces a 32-bit product, and the accumulator adds that product into its running sum. It is built for low power. Operand registers load only on an accepted start. Iteration stops as soon as the remaining multiplier bits are zero, and zero operands bypass iteration entirely.

---
 rtl/mult_seq16.sv | 101 ++++++++++
 tb/tb_mult_seq16.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq16.sv
// Sequential unsigned shift-add multiplier with start/done handshake.
// Iteration ends early once the remaining multiplier bits are zero; zero operands skip CALC.
module mult_seq16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [2*WIDTH-1:0] sum, sum_nxt, sum_add;
  logic [2*WIDTH-1:0] product_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt, mplier_shr;
  logic [CW-1:0]      count, count_nxt;
  logic               done_nxt;
  logic               last;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      sum     <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      sum     <= sum_nxt;
      count   <= count_nxt;
      product <= product_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    sum_nxt     = sum;
    count_nxt   = count;
    product_nxt = product;
    done_nxt    = 1'b0;

    sum_add    = mplier[0] ? (sum + mcand) : sum;
    mplier_shr = mplier >> 1;
    last       = (mplier_shr == '0) || (count == CW'(WIDTH - 1));

    unique case (state)
      IDLE: begin
        if (start) begin
          if ((a == '0) || (b == '0)) begin
            product_nxt = '0;
            done_nxt    = 1'b1;
          end else begin
            // Operand registers toggle only here, on an accepted start.
            mcand_nxt  = {{WIDTH{1'b0}}, a};
            mplier_nxt = b;
            sum_nxt    = '0;
            count_nxt  = '0;
            state_nxt  = CALC;
          end
        end
      end
      CALC: begin
        sum_nxt    = sum_add;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier_shr;
        count_nxt  = count + CW'(1);
        if (last) begin
          product_nxt = sum_add;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  // A completion always returns to IDLE, so done and busy are never high together.
  no_done_while_busy: assert property (@(posedge clk) disable iff (!clr_n) !(busy && done));

endmodule

// File: tb/tb_mult_seq16.sv
// Directed self-checking bench for mult_seq16: latency, early exit, zero bypass,
// ignored starts, back-to-back starts and asynchronous reset.
module tb_mult_seq16;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mult_seq16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Issue one start in cycle 0 and observe ncyc following cycles at the negedge.
  task automatic watch(input logic [15:0] av, input logic [15:0] bv, input int ncyc,
                       output int first_busy, output int last_busy, output int busy_cnt,
                       output int done_cyc, output int done_cnt, output logic [31:0] prod);
    first_busy = 0; last_busy = 0; busy_cnt = 0;
    done_cyc = 0; done_cnt = 0; prod = 'x;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = c;
        last_busy = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          prod = product;
        end
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b0; a = '0; b = '0;
    clr_n = 1'b1;
    #3 clr_n = 1'b0;
    #9;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (product !== 32'h0) begin fails++; $display("FAIL reset_product: got %0h expected 0", product); end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_basic();
    int fb, lb, bc, dc, dn; logic [31:0] p;
    watch(16'd3, 16'd5, 8, fb, lb, bc, dc, dn, p);
    checks++; if (fb !== 1) begin fails++; $display("FAIL basic_first_busy: got %0d expected 1", fb); end
    checks++; if (lb !== 3) begin fails++; $display("FAIL basic_last_busy: got %0d expected 3", lb); end
    checks++; if (bc !== 3) begin fails++; $display("FAIL basic_busy_cnt: got %0d expected 3", bc); end
    checks++; if (dc !== 4) begin fails++; $display("FAIL basic_done_cycle: got %0d expected 4", dc); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL basic_done_cnt: got %0d expected 1", dn); end
    checks++; if (p !== 32'd15) begin fails++; $display("FAIL basic_product: got %0h expected f", p); end
    checks++; if (product !== 32'd15) begin fails++; $display("FAIL basic_product_held: got %0h expected f", product); end
  endtask

  task automatic test_max();
    int fb, lb, bc, dc, dn; logic [31:0] p;
    watch(16'hFFFF, 16'hFFFF, 20, fb, lb, bc, dc, dn, p);
    checks++; if (fb !== 1) begin fails++; $display("FAIL max_first_busy: got %0d expected 1", fb); end
    checks++; if (lb !== 16) begin fails++; $display("FAIL max_last_busy: got %0d expected 16", lb); end
    checks++; if (bc !== 16) begin fails++; $display("FAIL max_busy_cnt: got %0d expected 16", bc); end
    checks++; if (dc !== 17) begin fails++; $display("FAIL max_done_cycle: got %0d expected 17", dc); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL max_done_cnt: got %0d expected 1", dn); end
    checks++; if (p !== 32'hFFFE0001) begin fails++; $display("FAIL max_product: got %0h expected fffe0001", p); end
  endtask

  task automatic test_zero();
    int fb, lb, bc, dc, dn; logic [31:0] p;
    watch(16'h1234, 16'h0000, 4, fb, lb, bc, dc, dn, p);
    checks++; if (bc !== 0) begin fails++; $display("FAIL zero_b_busy_cnt: got %0d expected 0", bc); end
    checks++; if (dc !== 1) begin fails++; $display("FAIL zero_b_done_cycle: got %0d expected 1", dc); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL zero_b_done_cnt: got %0d expected 1", dn); end
    checks++; if (p !== 32'h0) begin fails++; $display("FAIL zero_b_product: got %0h expected 0", p); end
    watch(16'h0000, 16'h00FF, 4, fb, lb, bc, dc, dn, p);
    checks++; if (bc !== 0) begin fails++; $display("FAIL zero_a_busy_cnt: got %0d expected 0", bc); end
    checks++; if (dc !== 1) begin fails++; $display("FAIL zero_a_done_cycle: got %0d expected 1", dc); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL zero_a_done_cnt: got %0d expected 1", dn); end
    checks++; if (p !== 32'h0) begin fails++; $display("FAIL zero_a_product: got %0h expected 0", p); end
  endtask

  task automatic test_ignored_start();
    int fb = 0, lb = 0, bc = 0, dc = 0, dn = 0;
    logic [31:0] p = 'x;
    @(negedge clk);
    a = 16'd7; b = 16'h8000; start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) begin bc++; if (fb == 0) fb = c; lb = c; end
      if (done) begin dn++; if (dc == 0) begin dc = c; p = product; end end
      start = 1'b0;
      if (c == 5) begin a = 16'd1; b = 16'd1; start = 1'b1; end
    end
    checks++; if (fb !== 1) begin fails++; $display("FAIL ign_first_busy: got %0d expected 1", fb); end
    checks++; if (lb !== 16) begin fails++; $display("FAIL ign_last_busy: got %0d expected 16", lb); end
    checks++; if (bc !== 16) begin fails++; $display("FAIL ign_busy_cnt: got %0d expected 16", bc); end
    checks++; if (dc !== 17) begin fails++; $display("FAIL ign_done_cycle: got %0d expected 17", dc); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL ign_done_cnt: got %0d expected 1", dn); end
    checks++; if (p !== 32'h00038000) begin fails++; $display("FAIL ign_product: got %0h expected 38000", p); end
    checks++; if (product !== 32'h00038000) begin fails++; $display("FAIL ign_product_held: got %0h expected 38000", product); end
  endtask

  task automatic test_back_to_back();
    int dn = 0, d1 = 0, d2 = 0, bc = 0, b2 = 0;
    logic [31:0] p1 = 'x, p2 = 'x, p_mid = 'x;
    @(negedge clk);
    a = 16'd2; b = 16'd2; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy) begin bc++; if (c > 3 && b2 == 0) b2 = c; end
      if (c == 4) p_mid = product;
      if (done) begin
        dn++;
        if (d1 == 0) begin d1 = c; p1 = product; end
        else if (d2 == 0) begin d2 = c; p2 = product; end
      end
      if (c == 3) begin a = 16'd10; b = 16'd1; start = 1'b1; end
    end
    checks++; if (d1 !== 3) begin fails++; $display("FAIL b2b_done1_cycle: got %0d expected 3", d1); end
    checks++; if (p1 !== 32'd4) begin fails++; $display("FAIL b2b_product1: got %0h expected 4", p1); end
    checks++; if (b2 !== 4) begin fails++; $display("FAIL b2b_busy2_cycle: got %0d expected 4", b2); end
    checks++; if (p_mid !== 32'd4) begin fails++; $display("FAIL b2b_product_mid: got %0h expected 4", p_mid); end
    checks++; if (d2 !== 5) begin fails++; $display("FAIL b2b_done2_cycle: got %0d expected 5", d2); end
    checks++; if (p2 !== 32'd10) begin fails++; $display("FAIL b2b_product2: got %0h expected a", p2); end
    checks++; if (dn !== 2) begin fails++; $display("FAIL b2b_done_cnt: got %0d expected 2", dn); end
    checks++; if (bc !== 3) begin fails++; $display("FAIL b2b_busy_cnt: got %0d expected 3", bc); end
  endtask

  task automatic test_reset_mid();
    int fb, lb, bc, dc, dn; int late_done = 0; logic busy8 = 1'b0;
    logic [31:0] p;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (c == 8) busy8 = busy;
    end
    checks++; if (busy8 !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before: got %0b expected 1", busy8); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %0b expected 0", done); end
    checks++; if (product !== 32'h0) begin fails++; $display("FAIL rst_mid_product: got %0h expected 0", product); end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++; if (late_done !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", late_done); end
    watch(16'd6, 16'd7, 6, fb, lb, bc, dc, dn, p);
    checks++; if (bc !== 3) begin fails++; $display("FAIL rst_after_busy_cnt: got %0d expected 3", bc); end
    checks++; if (dc !== 4) begin fails++; $display("FAIL rst_after_done_cycle: got %0d expected 4", dc); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL rst_after_done_cnt: got %0d expected 1", dn); end
    checks++; if (p !== 32'd42) begin fails++; $display("FAIL rst_after_product: got %0h expected 2a", p); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
